// File: rtl/dec3_core.sv
// Binary-to-one-hot decoder: combinational one-hot output plus a registered copy with valid.
// The decode is a predecode tree (low/high half one-hots ANDed), so it stays shallow at WIDTH=6.
module dec3_core #(
  parameter int WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  input  logic [WIDTH-1:0]      in,
  input  logic                  en,
  output logic [2**WIDTH-1:0]   out,
  output logic [2**WIDTH-1:0]   out_q,
  output logic                  out_q_vld
);

  localparam int N    = 2**WIDTH;
  localparam int LO_W = (WIDTH + 1) / 2;
  localparam int HI_W = WIDTH - LO_W;
  localparam int LO_N = 2**LO_W;
  localparam int HI_N = 2**HI_W;

  logic [LO_N-1:0] lo_hot;
  logic [HI_N-1:0] hi_hot;
  logic [N-1:0]    out_q_reg;
  logic            out_q_vld_reg;

  genvar gi;

  generate
    for (gi = 0; gi < LO_N; gi++) begin : g_lo
      assign lo_hot[gi] = (in[LO_W-1:0] == LO_W'(gi));
    end

    // Enable is folded into the high predecode so it gates every cross-product once.
    if (HI_W > 0) begin : g_hi_split
      for (gi = 0; gi < HI_N; gi++) begin : g_hi
        assign hi_hot[gi] = en && (in[WIDTH-1:LO_W] == HI_W'(gi));
      end
    end else begin : g_hi_none
      assign hi_hot[0] = en;
    end

    for (gi = 0; gi < N; gi++) begin : g_cross
      assign out[gi] = hi_hot[gi / LO_N] & lo_hot[gi % LO_N];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      out_q_reg     <= '0;
      out_q_vld_reg <= 1'b0;
    end else begin
      out_q_reg     <= out;
      out_q_vld_reg <= en;
    end
  end

  assign out_q     = out_q_reg;
  assign out_q_vld = out_q_vld_reg;

endmodule

// File: tb/tb_dec3_core.sv
// Self-checking bench for dec3_core at WIDTH=3, 4 and 6 against a 1<<in reference
// and a one-cycle-delayed register model that is cleared while rst_aL is low.
module tb_dec3_core;

  logic        clk = 1'b0;
  logic        rst_aL;

  logic [2:0]  in3;
  logic        en3;
  logic [7:0]  out3, out_q3;
  logic        vld3;

  logic [3:0]  in4;
  logic        en4;
  logic [15:0] out4, out_q4;
  logic        vld4;

  logic [5:0]  in6;
  logic        en6;
  logic [63:0] out6, out_q6;
  logic        vld6;

  int n_checks = 0;
  int n_fail   = 0;

  dec3_core #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_aL(rst_aL), .in(in3), .en(en3),
    .out(out3), .out_q(out_q3), .out_q_vld(vld3)
  );

  dec3_core #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_aL(rst_aL), .in(in4), .en(en4),
    .out(out4), .out_q(out_q4), .out_q_vld(vld4)
  );

  dec3_core #(.WIDTH(6)) u_dut6 (
    .clk(clk), .rst_aL(rst_aL), .in(in6), .en(en6),
    .out(out6), .out_q(out_q6), .out_q_vld(vld6)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_aL = 1'b0;
    in3 = 3'd5; en3 = 1'b1;
    in4 = 4'd9; en4 = 1'b1;
    in6 = 6'd33; en6 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_q3 !== 8'h00 || vld3 !== 1'b0) begin
      n_fail++; $display("FAIL reset_w3: out_q=%h vld=%b, required 00/0", out_q3, vld3);
    end
    n_checks++;
    if (out_q4 !== 16'h0 || vld4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_w4: out_q=%h vld=%b, required 0000/0", out_q4, vld4);
    end
    n_checks++;
    if (out_q6 !== 64'h0 || vld6 !== 1'b0) begin
      n_fail++; $display("FAIL reset_w6: out_q=%h vld=%b, required 0/0", out_q6, vld6);
    end
    n_checks++;
    if (out3 !== 8'h20) begin
      n_fail++; $display("FAIL reset_comb: out=%h, required 20", out3);
    end
    $display("txn reset: out_q3=%h vld3=%b out3=%h", out_q3, vld3, out3);
    @(negedge clk);
    rst_aL = 1'b1;
  endtask

  task automatic test_comb_sweep();
    int pass_cnt = 0;
    logic [7:0] exp;
    en3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in3 = 3'(i);
      #15;
      exp = 8'd1 << i;
      n_checks++;
      if (out3 !== exp) begin
        n_fail++; $display("FAIL comb_sweep in=%0d: out=%h, required %h", i, out3, exp);
      end else begin
        pass_cnt++;
      end
      $display("txn comb_sweep: in=%0d out=%h", i, out3);
    end
    n_checks++;
    if (pass_cnt != 8) begin
      n_fail++; $display("FAIL comb_sweep_count: passes=%0d, required 8", pass_cnt);
    end
  endtask

  task automatic test_enable_gating();
    @(negedge clk);
    in3 = 3'd5; en3 = 1'b0;
    #1;
    n_checks++;
    if (out3 !== 8'h00) begin
      n_fail++; $display("FAIL gate_comb_off: out=%h, required 00", out3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_q3 !== 8'h00 || vld3 !== 1'b0) begin
      n_fail++; $display("FAIL gate_reg_off: out_q=%h vld=%b, required 00/0", out_q3, vld3);
    end
    $display("txn gate_off: out=%h out_q=%h vld=%b", out3, out_q3, vld3);
    @(negedge clk);
    en3 = 1'b1;
    #1;
    n_checks++;
    if (out3 !== 8'h20) begin
      n_fail++; $display("FAIL gate_comb_on: out=%h, required 20", out3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_q3 !== 8'h20 || vld3 !== 1'b1) begin
      n_fail++; $display("FAIL gate_reg_on: out_q=%h vld=%b, required 20/1", out_q3, vld3);
    end
    $display("txn gate_on: out=%h out_q=%h vld=%b", out3, out_q3, vld3);
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{1, 2, 7, 0};
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in3 = 3'(vals[i]); en3 = 1'b1;
      @(posedge clk); #1;
      exp = 8'd1 << vals[i];
      n_checks++;
      if (out_q3 !== exp || vld3 !== 1'b1) begin
        n_fail++; $display("FAIL pipeline step %0d: out_q=%h vld=%b, required %h/1", i, out_q3, vld3, exp);
      end
      $display("txn pipeline: in=%0d out_q=%h vld=%b", vals[i], out_q3, vld3);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in3 = 3'd7; en3 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_q3 !== 8'h80 || vld3 !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: out_q=%h vld=%b, required 80/1", out_q3, vld3);
    end
    @(negedge clk);
    #2 rst_aL = 1'b0;
    #1;
    n_checks++;
    if (out_q3 !== 8'h00 || vld3 !== 1'b0) begin
      n_fail++; $display("FAIL areset_immediate: out_q=%h vld=%b, required 00/0", out_q3, vld3);
    end
    in3 = 3'd3; en3 = 1'b1;
    #1;
    n_checks++;
    if (out3 !== 8'h08) begin
      n_fail++; $display("FAIL areset_comb: out=%h, required 08", out3);
    end
    $display("txn areset: out_q=%h vld=%b out=%h", out_q3, vld3, out3);
    @(negedge clk);
    rst_aL = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_q3 !== 8'h08 || vld3 !== 1'b1) begin
      n_fail++; $display("FAIL areset_release: out_q=%h vld=%b, required 08/1", out_q3, vld3);
    end
    $display("txn areset_release: out_q=%h vld=%b", out_q3, vld3);
  endtask

  task automatic test_param_sweep();
    logic [15:0] exp4;
    logic [63:0] exp6;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in4 = 4'(i); en4 = 1'b1;
      #1;
      exp4 = 16'd1 << i;
      n_checks++;
      if (out4 !== exp4) begin
        n_fail++; $display("FAIL w4_comb in=%0d: out=%h, required %h", i, out4, exp4);
      end
      if (i == 15) begin
        n_checks++;
        if (out4 !== 16'h8000) begin
          n_fail++; $display("FAIL w4_msb: out=%h, required 8000", out4);
        end
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_q4 !== exp4 || vld4 !== 1'b1 || $countones(out_q4) != 1) begin
        n_fail++; $display("FAIL w4_reg in=%0d: out_q=%h vld=%b, required %h/1", i, out_q4, vld4, exp4);
      end
      $display("txn w4: in=%0d out=%h out_q=%h", i, out4, out_q4);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      in6 = 6'(i); en6 = 1'b1;
      #1;
      exp6 = 64'd1 << i;
      n_checks++;
      if (out6 !== exp6) begin
        n_fail++; $display("FAIL w6_comb in=%0d: out=%h, required %h", i, out6, exp6);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_q6 !== exp6 || vld6 !== 1'b1 || $countones(out_q6) != 1) begin
        n_fail++; $display("FAIL w6_reg in=%0d: out_q=%h vld=%b, required %h/1", i, out_q6, vld6, exp6);
      end
      $display("txn w6: in=%0d out=%h out_q=%h", i, out6, out_q6);
    end
  endtask

  task automatic test_random();
    logic [7:0] mdl_q;
    logic       mdl_vld;
    logic [7:0] exp;
    @(negedge clk);
    rst_aL = 1'b0;
    mdl_q = 8'h00; mdl_vld = 1'b0;
    #1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_q3 !== mdl_q || vld3 !== mdl_vld) begin
        n_fail++; $display("FAIL rand_reg cyc=%0d: out_q=%h vld=%b, required %h/%b", c, out_q3, vld3, mdl_q, mdl_vld);
      end
      in3    = 3'($urandom);
      en3    = 1'($urandom % 2);
      rst_aL = (($urandom % 8) != 0);
      #1;
      exp = en3 ? (8'd1 << in3) : 8'h00;
      n_checks++;
      if (out3 !== exp) begin
        n_fail++; $display("FAIL rand_comb cyc=%0d: in=%0d en=%b out=%h, required %h", c, in3, en3, out3, exp);
      end
      if (!rst_aL) begin
        mdl_q = 8'h00; mdl_vld = 1'b0;
        n_checks++;
        if (out_q3 !== 8'h00 || vld3 !== 1'b0) begin
          n_fail++; $display("FAIL rand_areset cyc=%0d: out_q=%h vld=%b, required 00/0", c, out_q3, vld3);
        end
      end
      @(posedge clk);
      if (rst_aL) begin
        mdl_q   = en3 ? (8'd1 << in3) : 8'h00;
        mdl_vld = en3;
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_q3 !== mdl_q || vld3 !== mdl_vld) begin
      n_fail++; $display("FAIL rand_reg_final: out_q=%h vld=%b, required %h/%b", out_q3, vld3, mdl_q, mdl_vld);
    end
    $display("txn random: 1000 cycles done");
    rst_aL = 1'b1;
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_enable_gating();
    test_back_to_back();
    test_async_reset();
    test_param_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec3_core.md
Name: dec3_core

Overview:
- Binary-to-one-hot decoder, default 3-bit select to 8 one-hot lines.
- Used for register-file write-enable selection, issue-slot selection and similar.
- Two outputs:
  - a combinational one-hot output for same-cycle use;
  - a registered copy with a valid flag for pipelined consumers.
- Must match the team golden decoder (out = 1 << in) bit-for-bit on the combinational path whenever enabled.

Parameters:
- WIDTH, 3: select width in bits; output width is 2**WIDTH. Legal range 1..6.

Ports:
- clk  input  1  rising-edge clock.
- rst_aL  input  1  asynchronous active-low reset.
- in  input  WIDTH  binary select index.
- en  input  1  decode enable; when low, no output line may be asserted.
- out  output  2**WIDTH  combinational one-hot decode of in, gated by en.
- out_q  output  2**WIDTH  registered copy of out, one cycle later.
- out_q_vld  output  1  registered en; high when out_q holds a valid one-hot word.

Behaviour:
- Combinational path (zero latency):
  - out[k] = en AND (in == k), for k = 0..2**WIDTH-1.
  - en=1: exactly one bit set, at position in; equivalently out = 1 << in.
  - en=0: out = all zeros.
  - X/Z on in with en=1 is not a legal input; behaviour is not required.
- Structure:
  - Build the decode as a predecode tree: split in into a low half and a high half, decode each half to one-hot, then AND the cross-products.
  - A flat compare chain is functionally acceptable.
  - Output must be identical to the 1 << in reference for every in.
  - No latches; purely combinational from in/en to out.
- Registered path:
  - Sampled on every rising clk edge: out_q <= out, out_q_vld <= en.
  - Latency is exactly 1 cycle; no hold or stall.
  - en=0 at an edge clears out_q to zero and drops out_q_vld.
- Reset:
  - rst_aL low asynchronously forces out_q = 0 and out_q_vld = 0, immediately and without waiting for clk.
  - While rst_aL is low, registers hold zero regardless of in/en.
  - out (combinational) is unaffected by reset and continues to follow in/en.
  - On rst_aL deassertion, the first rising edge with rst_aL high loads normally.
  - Reset asserted mid-stream discards the pending registered value; no ghost valid afterwards.
- Invariants:
  - out_q_vld=1 implies popcount(out_q) == 1.
  - out_q_vld=0 implies out_q == 0.
- Boundaries:
  - in = 0 gives out bit 0 only.
  - in = 2**WIDTH-1 gives the MSB only; no wrap and no overflow into an extra bit.
  - Back-to-back changes of in on consecutive cycles each appear on out_q exactly one cycle later, in order.

Test Plan:
- Exhaustive combinational sweep, WIDTH=3, en=1, in=0..7, 15 time units settle each:
  - out = 8'b0000_0001, 8'b0000_0010, ... 8'b1000_0000.
  - Compare against the golden decoder (out = 1 << in) each step; pass count must equal 8.
- Enable gating:
  - en=0 with in=5 -> out=8'h00; after one clk, out_q=8'h00 and out_q_vld=0.
  - Raise en=1 -> out=8'h20 immediately; after next edge, out_q=8'h20 and out_q_vld=1.
- Pipeline ordering:
  - in=1,2,7,0 on consecutive edges with en=1 -> out_q = 8'h02, 8'h04, 8'h80, 8'h01 on the following edges, out_q_vld=1 throughout.
- Asynchronous reset:
  - With out_q=8'h80 and out_q_vld=1, drive rst_aL low between edges -> out_q=0 and out_q_vld=0 at once, before the next clk edge.
  - Release rst_aL with in=3, en=1 -> out_q=8'h08 after the first edge.
- Parameter sweep:
  - Instantiate WIDTH=4 and WIDTH=6 and sweep all in values -> out = 1 << in.
  - MSB case: WIDTH=4, in=15 -> out=16'h8000.
  - After each edge, out_q matches and popcount(out_q)=1.
- Random:
  - 1000 cycles of random in/en/rst_aL at WIDTH=3.
  - Scoreboard checks out against 1 << in when en=1 (0 when en=0).
  - Scoreboard checks out_q/out_q_vld against a one-cycle-delayed model that is zeroed while rst_aL is low.
